// File: rtl/produto_arbiter.sv
// produto_arbiter: round-robin share of one A*B / A+B unit; optional PRODUTO_ARB_STATS_EN adds op/mul counters
module produto_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  input  logic [N_REQ-1:0]         req_mode,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2*W-1:0]           rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
`ifdef PRODUTO_ARB_STATS_EN
  output logic [15:0]              op_count,
  output logic [15:0]              mul_count,
`endif
  output logic                     busy
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, gnt_id, id_q, j;
  logic [IW:0] sum;
  logic found, accept, mode_q;
  logic [W-1:0] a_q, b_q;
  // round-robin search from rr_ptr; scanning backwards lets the nearest valid requester win
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    sum = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      j = IW'(sum >= (IW+1)'(N_REQ) ? sum - (IW+1)'(N_REQ) : sum);
      if (req_valid[j]) begin
        found = 1'b1;
        gnt_id = j;
      end
    end
  end
  assign accept    = (state == IDLE) && found && !rst;
  assign req_ready = accept ? N_REQ'(1) << gnt_id : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  // next-state: accept starts an op, EXEC lasts one cycle, RESP waits for the consumer
  always_comb begin
    state_nx = (state == IDLE) ? (accept ? EXEC : IDLE) :
               (state == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  // operand capture, pointer advance and result computation
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      if (accept) begin
        a_q    <= req_a[gnt_id*W +: W];
        b_q    <= req_b[gnt_id*W +: W];
        mode_q <= req_mode[gnt_id];
        id_q   <= gnt_id;
        rr_ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (state == EXEC) begin
        rsp_data <= mode_q ? (2*W)'(a_q) + (2*W)'(b_q) : (2*W)'(a_q) * (2*W)'(b_q);
        rsp_id   <= id_q;
      end
    end
  end
`ifdef PRODUTO_ARB_STATS_EN
  // saturating counts of completed response handshakes; mode_q still holds the op's mode in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count  <= '0;
      mul_count <= '0;
    end else if (state == RESP && rsp_ready) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (!mode_q && mul_count != 16'hFFFF) mul_count <= mul_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_produto_arbiter.sv
// tb_produto_arbiter: directed and random checks of produto_arbiter against a behavioural model
module tb_produto_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_mode, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, busy;
  logic [2*W-1:0] rsp_data;
  logic [1:0] rsp_id;
`ifdef PRODUTO_ARB_STATS_EN
  logic [15:0] op_count, mul_count;
`endif
  int checks = 0;
  int errors = 0;
  int ptr = 0;
  int exp_ops = 0;
  int exp_muls = 0;
  int last_data = 0;
  produto_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_mode(req_mode), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef PRODUTO_ARB_STATS_EN
    .op_count(op_count), .mul_count(mul_count),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [N-1:0] mask, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic [N-1:0] md, input int stall);
    int g, opa, opb, expd;
    req_valid = mask;
    req_a = a;
    req_b = b;
    req_mode = md;
    rsp_ready = 1'b0;
    #1;
    g = pick(mask, ptr);
    chk("grant", req_ready, 32'(1) << g);
    chk("busy_idle", busy, 0);
    step();
    ptr = (g + 1) % N;
    opa = int'(a[g*W +: W]);
    opb = int'(b[g*W +: W]);
    expd = md[g] ? opa + opb : opa * opb;
    req_valid[g] = 1'b0;
    chk("exec_ready", req_ready, 0);
    chk("exec_valid", rsp_valid, 0);
    chk("exec_busy", busy, 1);
    step();
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, expd);
    chk("resp_id", rsp_id, g);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, expd);
      chk("hold_id", rsp_id, g);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_ops++;
    if (!md[g]) exp_muls++;
    last_data = expd;
    chk("done_valid", rsp_valid, 0);
    chk("done_data", rsp_data, expd);
    chk("done_busy", busy, 0);
    req_valid = '0;
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_mode = '0;
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 2; c++) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_busy", busy, 0);
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("idle_noreq", req_ready, 0);
    step();
    chk("idle_stay", busy, 0);
    run_op(4'b0001, 8'h02, 8'h02, 4'b0000, 0);
    run_op(4'b0001, 8'h02, 8'h02, 4'b0001, 0);
    run_op(4'b0001, 8'h03, 8'h03, 4'b0000, 0);
    run_op(4'b0001, 8'h03, 8'h03, 4'b0001, 0);
    for (int r = 0; r < 5; r++) run_op(4'b1111, 8'hE4, 8'h1B, 4'b1010, 0);
    run_op(4'b1111, 8'hFF, 8'hFF, 4'b0000, 5);
    run_op(4'b1111, 8'h9C, 8'h63, 4'b0101, 0);
    run_op(4'b0100, 8'h30, 8'h20, 4'b0000, 0);
    run_op(4'b0011, 8'h0B, 8'h0E, 4'b0000, 0);
    run_op(4'b0011, 8'h0B, 8'h0E, 4'b0010, 0);
    for (int r = 0; r < 30; r++)
      run_op(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    req_valid = 4'b0100;
    req_a = 8'h30;
    req_b = 8'h30;
    req_mode = 4'b0000;
    step();
    req_valid = '0;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("mid_valid", rsp_valid, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_data", rsp_data, 0);
    rst = 1'b0;
    ptr = 0;
    exp_ops = 0;
    exp_muls = 0;
`ifdef PRODUTO_ARB_STATS_EN
    chk("op_count_rst", op_count, 0);
`endif
    run_op(4'b1111, 8'h5A, 8'hA5, 4'b0000, 0);
    run_op(4'b1111, 8'h5A, 8'hA5, 4'b0010, 1);
    run_op(4'b1111, 8'h5A, 8'hA5, 4'b0000, 0);
`ifdef PRODUTO_ARB_STATS_EN
    chk("op_count", op_count, exp_ops);
    chk("mul_count", mul_count, exp_muls);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
